// File: rtl/prco_fetch_pkg.sv
// prco_fetch_pkg
//   Shared constants for the PRCO fetch / memory-port sequencer: register
//   width, default reset vector and the 3-bit FSM state encodings.
//   Ports: none (package).
package prco_fetch_pkg;

    localparam int unsigned REG_WIDTH = 16;

    localparam logic [15:0] PRCO_RESET_VECTOR = 16'h0000;

    // Fetch/LSU sequencer states.
    localparam logic [2:0] S_FETCH = 3'd0;
    localparam logic [2:0] S_FWAIT = 3'd1;
    localparam logic [2:0] S_EXEC  = 3'd2;
    localparam logic [2:0] S_LSU   = 3'd3;
    localparam logic [2:0] S_LWAIT = 3'd4;
    localparam logic [2:0] S_HALT  = 3'd5;

    typedef logic [REG_WIDTH-1:0] word_t;

endpackage

// File: rtl/prco_fetch.sv
// prco_fetch
//   Program counter, instruction fetch and single-port arbitration in front
//   of prco_lmem. Fetches the word at PC, latches it into the instruction
//   register, then waits in S_EXEC for either a load/store request from the
//   ALU stage or a retire (optionally with branch or halt).
//
// Ports
//   i_clk, i_reset           clock, asynchronous active-high reset
//   q_ce_fetch / q_ce_alu    fetch and load/store strobes to prco_lmem
//   q_mem_we/addr/dina       write enable, address and write data to prco_lmem
//   i_mem_ce_dec/ce_reg      prco_lmem fetch-valid / load-store-valid pulses
//   i_mem_douta              prco_lmem read data
//   q_ir, q_ir_pc, q_ir_valid instruction word, its address, update pulse
//   i_lsu_*                  ALU-stage request (req, we, addr, din)
//   q_lsu_dout, q_lsu_done   load result and completion pulse
//   i_retire, i_branch_*, i_halt  retire / redirect / stop controls
//   q_halted                 high while stopped
module prco_fetch
    import prco_fetch_pkg::*;
#(
    parameter int unsigned           P_PC_WIDTH     = 16,
    parameter logic [P_PC_WIDTH-1:0] P_RESET_VECTOR = P_PC_WIDTH'(PRCO_RESET_VECTOR)
) (
    input  logic                  i_clk,
    input  logic                  i_reset,

    output logic                  q_ce_fetch,
    output logic                  q_ce_alu,
    output logic                  q_mem_we,
    output logic [P_PC_WIDTH-1:0] q_mem_addr,
    output logic [REG_WIDTH-1:0]  q_mem_dina,
    input  logic                  i_mem_ce_dec,
    input  logic                  i_mem_ce_reg,
    input  logic [REG_WIDTH-1:0]  i_mem_douta,

    output logic [REG_WIDTH-1:0]  q_ir,
    output logic [P_PC_WIDTH-1:0] q_ir_pc,
    output logic                  q_ir_valid,

    input  logic                  i_lsu_req,
    input  logic                  i_lsu_we,
    input  logic [P_PC_WIDTH-1:0] i_lsu_addr,
    input  logic [REG_WIDTH-1:0]  i_lsu_din,
    output logic [REG_WIDTH-1:0]  q_lsu_dout,
    output logic                  q_lsu_done,

    input  logic                  i_retire,
    input  logic                  i_branch_en,
    input  logic [P_PC_WIDTH-1:0] i_branch_addr,
    input  logic                  i_halt,
    output logic                  q_halted
);

    logic [2:0]            state_q, state_d;
    logic [P_PC_WIDTH-1:0] pc_q, pc_d;

    word_t                 ir_q, ir_d;
    logic [P_PC_WIDTH-1:0] ir_pc_q, ir_pc_d;
    logic                  ir_valid_q, ir_valid_d;

    logic                  lsu_we_q, lsu_we_d;
    logic [P_PC_WIDTH-1:0] lsu_addr_q, lsu_addr_d;
    word_t                 lsu_din_q, lsu_din_d;
    word_t                 lsu_dout_q, lsu_dout_d;
    logic                  lsu_done_q, lsu_done_d;

    // Last driven address / write data, so the bus holds while idle.
    logic [P_PC_WIDTH-1:0] mem_addr_q, mem_addr_d;
    word_t                 mem_dina_q, mem_dina_d;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = 1'b0;
        lsu_we_d   = lsu_we_q;
        lsu_addr_d = lsu_addr_q;
        lsu_din_d  = lsu_din_q;
        lsu_dout_d = lsu_dout_q;
        lsu_done_d = 1'b0;

        case (state_q)
            S_FETCH: begin
                state_d = S_FWAIT;
            end

            S_FWAIT: begin
                if (i_mem_ce_dec) begin
                    ir_d       = i_mem_douta;
                    ir_pc_d    = pc_q;
                    ir_valid_d = 1'b1;
                    pc_d       = pc_q + P_PC_WIDTH'(1);  // wraps naturally at all-ones
                    state_d    = S_EXEC;
                end
            end

            S_EXEC: begin
                // A memory request wins over a same-cycle retire; the retire is dropped.
                if (i_lsu_req) begin
                    lsu_we_d   = i_lsu_we;
                    lsu_addr_d = i_lsu_addr;
                    lsu_din_d  = i_lsu_din;
                    state_d    = S_LSU;
                end else if (i_retire) begin
                    if (i_halt) begin
                        state_d = S_HALT;
                    end else begin
                        if (i_branch_en) begin
                            pc_d = i_branch_addr;
                        end
                        state_d = S_FETCH;
                    end
                end
            end

            S_LSU: begin
                state_d = S_LWAIT;
            end

            S_LWAIT: begin
                // Stores complete the same way; dout then carries the pre-write content.
                if (i_mem_ce_reg) begin
                    lsu_dout_d = i_mem_douta;
                    lsu_done_d = 1'b1;
                    state_d    = S_EXEC;
                end
            end

            S_HALT: begin
                state_d = S_HALT;
            end

            default: begin
                // Unused encodings park safely until the next reset.
                state_d = S_HALT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Memory port
    // ------------------------------------------------------------------
    always_comb begin
        mem_addr_d = mem_addr_q;
        mem_dina_d = mem_dina_q;
        if (state_q == S_FETCH) begin
            mem_addr_d = pc_q;
        end else if (state_q == S_LSU) begin
            mem_addr_d = lsu_addr_q;
            mem_dina_d = lsu_din_q;
        end
    end

    // The state register resets to S_FETCH, so the fetch strobe and the PC
    // on the address bus are masked while reset is held to present zeros.
    always_comb begin
        q_ce_fetch = (state_q == S_FETCH) && !i_reset;
        q_ce_alu   = (state_q == S_LSU);
        q_mem_we   = (state_q == S_LSU) && lsu_we_q;
        q_mem_addr = i_reset ? '0 : mem_addr_d;
        q_mem_dina = mem_dina_d;
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= S_FETCH;
            pc_q       <= P_RESET_VECTOR;
            ir_q       <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
            lsu_we_q   <= 1'b0;
            lsu_addr_q <= '0;
            lsu_din_q  <= '0;
            lsu_dout_q <= '0;
            lsu_done_q <= 1'b0;
            mem_addr_q <= '0;
            mem_dina_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
            lsu_we_q   <= lsu_we_d;
            lsu_addr_q <= lsu_addr_d;
            lsu_din_q  <= lsu_din_d;
            lsu_dout_q <= lsu_dout_d;
            lsu_done_q <= lsu_done_d;
            mem_addr_q <= mem_addr_d;
            mem_dina_q <= mem_dina_d;
        end
    end

    assign q_ir       = ir_q;
    assign q_ir_pc    = ir_pc_q;
    assign q_ir_valid = ir_valid_q;
    assign q_lsu_dout = lsu_dout_q;
    assign q_lsu_done = lsu_done_q;
    assign q_halted   = (state_q == S_HALT);

endmodule

// File: tb/tb_prco_fetch.sv
// tb_prco_fetch
//   Directed + randomized bench for prco_fetch. A behavioural prco_lmem
//   (one-cycle response, read-before-write) sits on the memory port; a
//   shadow copy of memory and a PC/IR model predict every observed value.
module tb_prco_fetch;

    logic        i_clk;
    logic        i_reset;
    logic        q_ce_fetch, q_ce_alu, q_mem_we;
    logic [15:0] q_mem_addr, q_mem_dina;
    logic        i_mem_ce_dec, i_mem_ce_reg;
    logic [15:0] i_mem_douta;
    logic [15:0] q_ir, q_ir_pc;
    logic        q_ir_valid;
    logic        i_lsu_req, i_lsu_we;
    logic [15:0] i_lsu_addr, i_lsu_din;
    logic [15:0] q_lsu_dout;
    logic        q_lsu_done;
    logic        i_retire, i_branch_en, i_halt;
    logic [15:0] i_branch_addr;
    logic        q_halted;

    prco_fetch dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .q_ce_fetch    (q_ce_fetch),
        .q_ce_alu      (q_ce_alu),
        .q_mem_we      (q_mem_we),
        .q_mem_addr    (q_mem_addr),
        .q_mem_dina    (q_mem_dina),
        .i_mem_ce_dec  (i_mem_ce_dec),
        .i_mem_ce_reg  (i_mem_ce_reg),
        .i_mem_douta   (i_mem_douta),
        .q_ir          (q_ir),
        .q_ir_pc       (q_ir_pc),
        .q_ir_valid    (q_ir_valid),
        .i_lsu_req     (i_lsu_req),
        .i_lsu_we      (i_lsu_we),
        .i_lsu_addr    (i_lsu_addr),
        .i_lsu_din     (i_lsu_din),
        .q_lsu_dout    (q_lsu_dout),
        .q_lsu_done    (q_lsu_done),
        .i_retire      (i_retire),
        .i_branch_en   (i_branch_en),
        .i_branch_addr (i_branch_addr),
        .i_halt        (i_halt),
        .q_halted      (q_halted)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // ---------------- prco_lmem model ----------------
    function automatic logic [15:0] init_word(input logic [15:0] a);
        case (a)
            16'h0000: return 16'h4fff;
            16'h0001: return 16'h16e0;
            16'h0002: return 16'h1ee0;
            16'h00aa: return 16'h00ca;
            default:  return (a * 16'h9e37) ^ 16'h5a5a ^ {a[7:0], a[15:8]};
        endcase
    endfunction

    logic [15:0] lmem [0:65535];
    bit          mem_init_done;
    bit          cap_fetch, cap_alu, cap_we;
    logic [15:0] cap_addr, cap_dina;
    bit          mem_ce_dec, mem_ce_reg;
    logic [15:0] mem_douta;
    bit          spur_dec, spur_reg;
    logic [15:0] spur_data;

    // Requests captured mid-cycle so the response edge never races the DUT.
    always @(negedge i_clk) begin
        cap_fetch <= q_ce_fetch;
        cap_alu   <= q_ce_alu;
        cap_we    <= q_mem_we;
        cap_addr  <= q_mem_addr;
        cap_dina  <= q_mem_dina;
    end

    always @(posedge i_clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 65536; i++) lmem[i] <= init_word(16'(i));
            mem_init_done <= 1'b1;
        end else if (cap_alu && cap_we) begin
            lmem[cap_addr] <= cap_dina;
        end
        mem_ce_dec <= cap_fetch;
        mem_ce_reg <= cap_alu;
        mem_douta  <= lmem[cap_addr];
    end

    assign i_mem_ce_dec = mem_ce_dec | spur_dec;
    assign i_mem_ce_reg = mem_ce_reg | spur_reg;
    assign i_mem_douta  = (spur_dec | spur_reg) ? spur_data : mem_douta;

    // ---------------- reference model ----------------
    logic [15:0] ref_mem [0:65535];
    logic [15:0] m_pc, m_ir, m_ir_pc, m_dout;
    int          n_cmp;
    int          n_err;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk1({tag, "_ce_fetch"}, q_ce_fetch, 1'b0);
        chk1({tag, "_ce_alu"}, q_ce_alu, 1'b0);
        chk1({tag, "_we"}, q_mem_we, 1'b0);
        chk({tag, "_addr"}, q_mem_addr, 16'h0000);
        chk({tag, "_dina"}, q_mem_dina, 16'h0000);
        chk({tag, "_ir"}, q_ir, 16'h0000);
        chk({tag, "_ir_pc"}, q_ir_pc, 16'h0000);
        chk1({tag, "_ir_valid"}, q_ir_valid, 1'b0);
        chk({tag, "_dout"}, q_lsu_dout, 16'h0000);
        chk1({tag, "_done"}, q_lsu_done, 1'b0);
        chk1({tag, "_halted"}, q_halted, 1'b0);
    endtask

    // Called in the fetch cycle; returns in the cycle q_ir_valid is high.
    task automatic fetch_seq();
        chk1("fetch_ce", q_ce_fetch, 1'b1);
        chk("fetch_addr", q_mem_addr, m_pc);
        chk1("fetch_no_alu", q_ce_alu, 1'b0);
        tick();
        chk1("fwait_ce", q_ce_fetch, 1'b0);
        chk1("fwait_irv", q_ir_valid, 1'b0);
        tick();
        chk1("ir_valid", q_ir_valid, 1'b1);
        chk("ir", q_ir, ref_mem[m_pc]);
        chk("ir_pc", q_ir_pc, m_pc);
        m_ir    = ref_mem[m_pc];
        m_ir_pc = m_pc;
        m_pc    = m_pc + 16'd1;
    endtask

    task automatic retire(input bit br, input logic [15:0] tgt, input bit hlt);
        i_retire      = 1'b1;
        i_branch_en   = br;
        i_branch_addr = tgt;
        i_halt        = hlt;
        tick();
        i_retire      = 1'b0;
        i_branch_en   = 1'b0;
        i_halt        = 1'b0;
        i_branch_addr = 16'($urandom);
        chk1("retire_done_low", q_lsu_done, 1'b0);
        chk1("retire_irv_low", q_ir_valid, 1'b0);
        if (hlt) begin
            chk1("halted", q_halted, 1'b1);
            chk1("halt_no_fetch", q_ce_fetch, 1'b0);
        end else begin
            if (br) m_pc = tgt;
            fetch_seq();
        end
    endtask

    // Called in S_EXEC; returns in the cycle q_lsu_done is high.
    task automatic lsu(input bit we, input logic [15:0] addr, input logic [15:0] din);
        i_lsu_req  = 1'b1;
        i_lsu_we   = we;
        i_lsu_addr = addr;
        i_lsu_din  = din;
        tick();
        i_lsu_req  = 1'b0;
        i_lsu_we   = 1'($urandom_range(0, 1));
        i_lsu_addr = 16'($urandom);
        i_lsu_din  = 16'($urandom);
        chk1("lsu_ce_alu", q_ce_alu, 1'b1);
        chk1("lsu_no_fetch", q_ce_fetch, 1'b0);
        chk1("lsu_we", q_mem_we, we);
        chk("lsu_addr", q_mem_addr, addr);
        chk("lsu_dina", q_mem_dina, din);
        chk1("lsu_done_early", q_lsu_done, 1'b0);
        chk1("lsu_irv_low", q_ir_valid, 1'b0);
        tick();
        chk1("lwait_ce_alu", q_ce_alu, 1'b0);
        chk1("lwait_we", q_mem_we, 1'b0);
        chk("lwait_addr_hold", q_mem_addr, addr);
        chk("lwait_dina_hold", q_mem_dina, din);
        chk1("lwait_done", q_lsu_done, 1'b0);
        tick();
        chk1("lsu_done", q_lsu_done, 1'b1);
        chk("lsu_dout", q_lsu_dout, ref_mem[addr]);
        chk("lsu_ir_hold", q_ir, m_ir);
        m_dout = ref_mem[addr];
        if (we) ref_mem[addr] = din;
    endtask

    // Idle S_EXEC cycles with stray memory pulses that must be ignored.
    task automatic idle_exec(input int n);
        for (int k = 0; k < n; k++) begin
            spur_dec  = 1'b1;
            spur_reg  = 1'b1;
            spur_data = 16'($urandom);
            tick();
            spur_dec = 1'b0;
            spur_reg = 1'b0;
            chk("idle_ir", q_ir, m_ir);
            chk("idle_ir_pc", q_ir_pc, m_ir_pc);
            chk("idle_dout", q_lsu_dout, m_dout);
            chk1("idle_irv", q_ir_valid, 1'b0);
            chk1("idle_done", q_lsu_done, 1'b0);
            chk1("idle_strobes", q_ce_fetch | q_ce_alu, 1'b0);
        end
    endtask

    initial begin
        int          op;
        int          strobes;
        logic [15:0] a;

        n_cmp = 0;
        n_err = 0;
        for (int i = 0; i < 65536; i++) ref_mem[i] = init_word(16'(i));
        i_reset = 1'b1;
        i_lsu_req = 1'b0; i_lsu_we = 1'b0; i_lsu_addr = 16'h0; i_lsu_din = 16'h0;
        i_retire = 1'b0; i_branch_en = 1'b0; i_branch_addr = 16'h0; i_halt = 1'b0;
        spur_dec = 1'b0; spur_reg = 1'b0; spur_data = 16'h0;
        m_pc = 16'h0000; m_ir = 16'h0; m_ir_pc = 16'h0; m_dout = 16'h0;

        repeat (3) tick();
        chk_all_zero("reset");

        // First fetch straight after reset release.
        i_reset = 1'b0;
        #1;
        fetch_seq();
        chk("first_ir_const", q_ir, 16'h4fff);

        // Sequential fetch.
        retire(1'b0, 16'h0, 1'b0);
        chk("seq_ir1", q_ir, 16'h16e0);
        retire(1'b0, 16'h0, 1'b0);
        chk("seq_ir2", q_ir, 16'h1ee0);

        // Branch.
        retire(1'b1, 16'h0010, 1'b0);
        chk("branch_ir_pc", q_ir_pc, 16'h0010);

        // Load, then store and read back.
        lsu(1'b0, 16'h00aa, 16'h1234);
        chk("load_const", q_lsu_dout, 16'h00ca);
        lsu(1'b1, 16'h00ab, 16'hbeef);
        lsu(1'b0, 16'h00ab, 16'h0000);
        chk("store_readback", q_lsu_dout, 16'hbeef);

        idle_exec(3);

        // PC wrap from 0xFFFF.
        retire(1'b1, 16'hffff, 1'b0);
        retire(1'b0, 16'h0, 1'b0);
        chk("wrap_ir_pc", q_ir_pc, 16'h0000);

        // Randomized mix of memory ops, retires and branches.
        for (int it = 0; it < 60; it++) begin
            op = int'($urandom_range(0, 4));
            a  = 16'h00a0 + 16'($urandom_range(0, 31));
            case (op)
                0: lsu(1'b0, a, 16'($urandom));
                1: lsu(1'b1, a, 16'($urandom));
                2: retire(1'b0, 16'($urandom), 1'b0);
                3: retire(1'b1, ($urandom_range(0, 3) == 0) ? 16'hffff : 16'($urandom), 1'b0);
                default: idle_exec(int'($urandom_range(1, 2)));
            endcase
        end

        // Reset while waiting for a load response.
        i_lsu_req  = 1'b1;
        i_lsu_we   = 1'b0;
        i_lsu_addr = 16'h00ab;
        tick();
        i_lsu_req = 1'b0;
        tick();
        i_reset = 1'b1;
        #1;
        chk_all_zero("midreset");
        tick();
        tick();
        i_reset = 1'b0;
        #1;
        m_pc = 16'h0000; m_ir = 16'h0; m_ir_pc = 16'h0; m_dout = 16'h0;
        fetch_seq();
        chk("post_reset_ir", q_ir, 16'h4fff);
        chk("post_reset_dout", q_lsu_dout, 16'h0000);

        // Halt with branch also asserted; halt wins, then stays quiet.
        retire(1'b1, 16'h0020, 1'b1);
        strobes = 0;
        i_lsu_req = 1'b1;
        i_retire  = 1'b1;
        for (int k = 0; k < 100; k++) begin
            spur_dec  = k[0];
            spur_reg  = ~k[0];
            spur_data = 16'($urandom);
            tick();
            if (q_ce_fetch || q_ce_alu || q_mem_we) strobes++;
        end
        i_lsu_req = 1'b0;
        i_retire  = 1'b0;
        spur_dec  = 1'b0;
        spur_reg  = 1'b0;
        chk("halt_quiet", 16'(strobes), 16'h0000);
        chk1("halt_held", q_halted, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
